// File: rtl/seg7_pkg.sv
// Shared types and constants for the 8-digit multiplexed 7-segment scan controller.
package seg7_pkg;

  localparam int NUM_DIGITS = 8;

  // Segment codes {g,f,e,d,c,b,a} for nibble values 0..F, index 0 first.
  localparam logic [0:15][6:0] SEG_TABLE = {
    7'h3f, 7'h06, 7'h5b, 7'h4f, 7'h66, 7'h6d, 7'h7d, 7'h27,
    7'h7f, 7'h6f, 7'h5f, 7'h7c, 7'h58, 7'h5e, 7'h7b, 7'h71
  };

  typedef enum logic {
    GUARD = 1'b0,
    DRIVE = 1'b1
  } state_e;

  typedef struct packed {
    logic       blank;
    logic       dot;
    logic [3:0] hex;
  } digit_t;

  localparam digit_t BLANK_DIGIT = '{blank: 1'b1, dot: 1'b0, hex: 4'h0};

endpackage

// File: rtl/seg7_hex_dec.sv
// Nibble to 7-segment pattern lookup, purely combinational.
module seg7_hex_dec
  import seg7_pkg::*;
(
  input  logic [3:0] i_hex,
  output logic [6:0] o_seg
);

  assign o_seg = SEG_TABLE[i_hex];

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed 8-digit 7-segment scan controller with guard intervals
// and frame-synchronous shadow-to-active buffer transfer.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int DIG_CYC   = 10000,
  parameter int GUARD_CYC = 100
) (
  input  logic       i_clk,
  input  logic       i_rstn,
  input  logic       i_en,
  input  logic       i_wr_en,
  input  logic [2:0] i_wr_addr,
  input  logic [3:0] i_wr_hex,
  input  logic       i_wr_dot,
  input  logic       i_wr_blank,
  input  logic       i_commit,
  output logic       o_busy,
  output logic       o_commit_done,
  output logic [7:0] o_seg_d,
  output logic [7:0] o_seg_com
);

  localparam int MAX_CYC = (DIG_CYC > GUARD_CYC) ? DIG_CYC : GUARD_CYC;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] DIG_LAST   = CNT_W'(DIG_CYC - 1);
  localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD_CYC - 1);
  localparam logic [2:0]       LAST_DIGIT = 3'(NUM_DIGITS - 1);

  state_e           state_r, state_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic [2:0]       idx_r, idx_s;
  digit_t           shadow_r [NUM_DIGITS];
  digit_t           active_r [NUM_DIGITS];
  digit_t           wr_s;
  digit_t           cur_s;
  logic             pending_r;
  logic             done_r;
  logic             boundary_s;
  logic             xfer_s;
  logic [6:0]       seg_s;
  logic [7:0]       seg_d_s, seg_com_s;
  logic [7:0]       seg_d_r, seg_com_r;

  assign boundary_s = i_en && (state_r == DRIVE) && (idx_r == LAST_DIGIT) && (cnt_r == DIG_LAST);
  assign xfer_s     = boundary_s && pending_r;

  assign wr_s.blank = i_wr_blank;
  assign wr_s.dot   = i_wr_dot;
  assign wr_s.hex   = i_wr_hex;

  // Scan state, cycle counter and digit index registers
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      state_r <= GUARD;
      cnt_r   <= CNT_ZERO;
      idx_r   <= 3'd0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      idx_r   <= idx_s;
    end
  end

  // Next scan position; disable parks the sequence at the start of digit 0
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    idx_s   = idx_r;
    if (!i_en) begin
      state_s = GUARD;
      cnt_s   = CNT_ZERO;
      idx_s   = 3'd0;
    end else begin
      case (state_r)
        GUARD: begin
          if (cnt_r == GUARD_LAST) begin
            state_s = DRIVE;
            cnt_s   = CNT_ZERO;
          end else begin
            cnt_s = cnt_r + CNT_ONE;
          end
        end
        DRIVE: begin
          if (cnt_r == DIG_LAST) begin
            state_s = GUARD;
            cnt_s   = CNT_ZERO;
            idx_s   = idx_r + 3'd1;
          end else begin
            cnt_s = cnt_r + CNT_ONE;
          end
        end
        default: begin
          state_s = GUARD;
          cnt_s   = CNT_ZERO;
          idx_s   = 3'd0;
        end
      endcase
    end
  end

  // Outputs are computed from the next state so they match the state entered on the edge
  assign cur_s = active_r[idx_s];

  seg7_hex_dec u_hex_dec (
    .i_hex (cur_s.hex),
    .o_seg (seg_s)
  );

  // Segment and common drive for the upcoming cycle
  always_comb begin
    seg_com_s = 8'h00;
    seg_d_s   = 8'h00;
    if (state_s == DRIVE) begin
      seg_com_s = 8'h01 << idx_s;
      if (cur_s.blank) begin
        seg_d_s = 8'h00;
      end else begin
        seg_d_s = {cur_s.dot, seg_s};
      end
    end else begin
      seg_com_s = 8'h00;
      seg_d_s   = 8'h00;
    end
  end

  // Shadow takes writes at any time; active only changes at a frame boundary
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        shadow_r[i] <= BLANK_DIGIT;
        active_r[i] <= BLANK_DIGIT;
      end
    end else begin
      if (i_wr_en) begin
        shadow_r[i_wr_addr] <= wr_s;
      end
      if (xfer_s) begin
        active_r <= shadow_r;
      end
    end
  end

  // Commit handshake and registered display outputs
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      pending_r <= 1'b0;
      done_r    <= 1'b0;
      seg_d_r   <= 8'h00;
      seg_com_r <= 8'h00;
    end else begin
      if (xfer_s) begin
        pending_r <= 1'b0;
      end else if (i_commit) begin
        pending_r <= 1'b1;
      end
      done_r    <= xfer_s;
      seg_d_r   <= seg_d_s;
      seg_com_r <= seg_com_s;
    end
  end

  assign o_busy        = pending_r;
  assign o_commit_done = done_r;
  assign o_seg_d       = seg_d_r;
  assign o_seg_com     = seg_com_r;

endmodule

// File: doc/seg7_scan_ctrl.md
# seg7_scan_ctrl

Time-multiplexed scan controller for the 8-digit common-cathode 7-segment display. Holds a shadow and an active 8-entry digit buffer (hex nibble, dot, blank per digit). Drives one digit at a time with a guard (all-off) interval between digits to suppress ghosting. Shadow-to-active transfer happens only at frame boundaries on request, so user logic (DIP/rotary/key front end) can update several digits atomically.

## Interface
- DIG_CYC, 10000: clock cycles each digit is driven; ≥1
- GUARD_CYC, 100: clock cycles all commons are off between digits; ≥1
- i_clk  in  1  system clock
- i_rstn  in  1  reset, synchronous, active-low
- i_en  in  1  scan enable; 0 forces display dark
- i_wr_en  in  1  write strobe to shadow buffer
- i_wr_addr  in  3  digit index 0..7 (bit n of o_seg_com)
- i_wr_hex  in  4  hex value 0x0..0xF
- i_wr_dot  in  1  decimal point on
- i_wr_blank  in  1  digit dark (overrides hex and dot)
- i_commit  in  1  request shadow→active transfer at next frame boundary
- o_busy  out  1  commit pending
- o_commit_done  out  1  one-cycle pulse when transfer happens
- o_seg_d  out  8  {dot, seg g..a}, active-high
- o_seg_com  out  8  digit select, one-hot active-high, or all zero

## Operation
- States: GUARD, DRIVE. A cycle counter and a 3-bit digit index advance the sequence.
- Sequence per digit n: GUARD for GUARD_CYC cycles, then DRIVE for DIG_CYC cycles, then n+1 (7 wraps to 0). Frame period is 8·(DIG_CYC+GUARD_CYC) cycles.
- In GUARD, o_seg_com=0 and o_seg_d=0.
- In DRIVE, o_seg_com=1<<n and o_seg_d={dot, hexdec(hex)} from active entry n. Blank entry gives o_seg_d=0 with com still one-hot.
- hexdec: 0 3f, 1 06, 2 5b, 3 4f, 4 66, 5 6d, 6 7d, 7 27, 8 7f, 9 6f, A 5f, b 7c, c 58, d 5e, E 7b, F 71.
- Writes: i_wr_en updates shadow[i_wr_addr] in the same cycle. Writes are accepted at any time and never affect the active buffer directly. Last write wins.
- Commit: i_commit sets the pending flag (o_busy=1). The frame boundary is the last DRIVE cycle of digit 7. At the boundary with pending=1, active←shadow (values held before that edge), pending←0, and o_commit_done pulses on the following cycle.
- Simultaneous events:
  - commit and boundary in the same cycle with pending=0: the transfer occurs at the next boundary.
  - write on the boundary cycle: goes to shadow only and appears at the next commit.
  - repeated commits while pending: absorbed, no extra transfer.
- i_en=0: on the next edge, state←GUARD, index←0, counter cleared, outputs 0. Shadow, active and pending are retained. No boundary occurs, so pending waits. On i_en return, the sequence restarts at GUARD of digit 0.
- Reset (any time, including mid-frame or with commit pending):
  - state GUARD, index 0, counter 0.
  - all shadow and active entries blank (hex 0, dot 0, blank 1).
  - pending 0, o_busy 0, o_commit_done 0, o_seg_d 8'h00, o_seg_com 8'h00.

## Timing
- All outputs are registered and change on i_clk rising edge. Outputs reflect the state entered on that edge, with no extra pipeline stage.
- After i_rstn goes high at edge E0, outputs are 0 for GUARD_CYC cycles. Digit 0 drives from E0+GUARD_CYC for DIG_CYC cycles.
- Commit latency is ≤ one frame period + 1 cycle from i_commit to o_commit_done.
- Active content changes only on the edge after the digit 7 DRIVE interval, so no partial frame is ever displayed.
- Counter width: $clog2(max(DIG_CYC,GUARD_CYC)). Terminal count is value-1. No counter overflow is possible.

## Structure
- Package seg7_pkg:
  - 16-entry segment-code constant table.
  - state enum {GUARD, DRIVE}.
  - digit-entry struct {blank, dot, hex[3:0]}.
  - NUM_DIGITS=8.
- Sub-module seg7_hex_dec: combinational nibble→7-bit lookup using the package table. It is the only decoder instance, fed by the active-buffer mux.
- Top: scan FSM and counter, shadow/active register arrays, commit logic, output registers.

## Test plan
All scenarios use DIG_CYC=4, GUARD_CYC=2.
- Reset release: o_seg_d and o_seg_com are 0 for 2 cycles. Then o_seg_com=8'h01 and o_seg_d=8'h00 (blank) for 4 cycles. o_busy=0.
- Write addr 3, hex A, dot 1, then commit. Within ≤49 cycles o_commit_done pulses once. Thereafter, during digit 3 drive, o_seg_com=8'h08 and o_seg_d=8'hDF. Digits 0–2 and 4–7 show 8'h00.
- Commit mid-frame (digit 2 driving): o_busy=1 until the boundary. Digit 3 keeps its old value for the rest of that frame. The new value appears from the next frame.
- Write addr 5 hex 7 and commit in the same cycle as the boundary with pending=0: no transfer this boundary. Transfer at the next boundary. Digit 5 then shows 8'h27 with com 8'h20.
- i_en low for 10 cycles mid-DRIVE of digit 4: outputs 0 from the next edge. On re-enable: 2 guard cycles, then com=8'h01. Pending commit is retained and completes at the following boundary.
- Reset asserted while pending with non-blank active data: all outputs 0 on the next edge, o_busy=0. After release, all digits are blank.
